// File: rtl/ysyx_24100029_btb_pkg.sv
// rtl/ysyx_24100029_btb_pkg.sv - shared types and constants for the associative BTB
package ysyx_24100029_btb_pkg;

  // Tag storage is sized for the widest possible split; upper bits stay zero
  localparam int TAG_MAX = 32;

  localparam logic [1:0] CTR_INIT = 2'b10;
  localparam logic [1:0] CTR_MAX  = 2'd3;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  typedef struct packed {
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
    logic [1:0]         ctr;
  } btb_entry_t;

  // Saturating 2-bit direction counter step
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
    return (ctr == 2'd0) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/ysyx_24100029_btb_victim.sv
// rtl/ysyx_24100029_btb_victim.sv - victim way selection: first free way, else round-robin pointer
module ysyx_24100029_btb_victim
  import ysyx_24100029_btb_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int PTR_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] victim,
  output logic             advance
);

  // Scan downwards so the lowest invalid way is the last one kept
  always_comb begin
    victim  = ptr;
    advance = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim  = PTR_W'(w);
        advance = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ysyx_24100029_btb_assoc.sv
// rtl/ysyx_24100029_btb_assoc.sv - N-way set-associative branch target buffer
module ysyx_24100029_btb_assoc
  import ysyx_24100029_btb_pkg::*;
#(
  parameter int WAYS         = 4,
  parameter int INDEX_WIDTH  = 3,
  parameter int OFFSET_WIDTH = 2,
  parameter int BRT_WIDTH    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          btb_pc,
  output logic                 btb_is_hit,
  output logic [31:0]          btb_npc,
  output logic [BRT_WIDTH-1:0] btb_br_type,
  output logic                 btb_taken,
  input  logic                 btb_commit,
  input  logic [31:0]          btb_commit_pc,
  input  logic [31:0]          btb_commit_npc,
  input  logic                 btb_commit_taken,
  input  logic [BRT_WIDTH-1:0] btb_commit_br_type,
  input  logic                 btb_flush
);

  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int TAG_W = 32 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int PTR_W = $clog2(WAYS);

  logic [WAYS-1:0]      valid_q [SETS];
  logic [PTR_W-1:0]     ptr_q   [SETS];
  btb_entry_t           mem_q   [SETS][WAYS];
  logic [BRT_WIDTH-1:0] type_q  [SETS][WAYS];

  logic [INDEX_WIDTH-1:0] rd_idx, wr_idx;
  logic [TAG_MAX-1:0]     rd_tag, wr_tag;
  logic                   rd_hit, wr_hit;
  logic [PTR_W-1:0]       rd_way, wr_way, vic_way, wr_sel;
  logic                   vic_adv, wr_en;
  btb_entry_t             wr_entry;
  logic                   unused_offset;

  assign rd_idx = btb_pc[OFFSET_WIDTH +: INDEX_WIDTH];
  assign wr_idx = btb_commit_pc[OFFSET_WIDTH +: INDEX_WIDTH];
  assign unused_offset = ^{btb_pc[OFFSET_WIDTH-1:0], btb_commit_pc[OFFSET_WIDTH-1:0]};

  // Zero-extend both tags into the package-wide tag field
  always_comb begin
    rd_tag = '0;
    wr_tag = '0;
    rd_tag[TAG_W-1:0] = btb_pc[31 -: TAG_W];
    wr_tag[TAG_W-1:0] = btb_commit_pc[31 -: TAG_W];
  end

  // Fetch-side tag match; lowest matching way wins
  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[rd_idx][w] && mem_q[rd_idx][w].tag == rd_tag) begin
        rd_hit = 1'b1;
        rd_way = PTR_W'(w);
      end
    end
  end

  // Commit-side tag match so a hit updates in place instead of duplicating
  always_comb begin
    wr_hit = 1'b0;
    wr_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[wr_idx][w] && mem_q[wr_idx][w].tag == wr_tag) begin
        wr_hit = 1'b1;
        wr_way = PTR_W'(w);
      end
    end
  end

  ysyx_24100029_btb_victim #(
    .WAYS  (WAYS),
    .PTR_W (PTR_W)
  ) u_victim (
    .valid   (valid_q[wr_idx]),
    .ptr     (ptr_q[wr_idx]),
    .victim  (vic_way),
    .advance (vic_adv)
  );

  assign btb_is_hit  = rd_hit;
  assign btb_npc     = rd_hit ? mem_q[rd_idx][rd_way].target : 32'd0;
  assign btb_br_type = rd_hit ? type_q[rd_idx][rd_way] : '0;
  assign btb_taken   = rd_hit && (mem_q[rd_idx][rd_way].ctr[1] ||
                                  type_q[rd_idx][rd_way] != BRT_WIDTH'(BR_COND));

  // Reset and flush both drop a same-cycle commit; misses not taken never allocate
  assign wr_en  = btb_commit && !reset && !btb_flush && (wr_hit || btb_commit_taken);
  assign wr_sel = wr_hit ? wr_way : vic_way;

  // New entry contents: hits keep training the counter, allocations start weakly taken
  always_comb begin
    wr_entry.tag    = wr_tag;
    wr_entry.target = btb_commit_npc;
    wr_entry.ctr    = wr_hit ? ctr_next(mem_q[wr_idx][wr_way].ctr, btb_commit_taken) : CTR_INIT;
  end

  // Valid bits and replacement pointers: cleared on reset/flush, set on allocation
  always_ff @(posedge clock) begin
    if (reset || btb_flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (wr_en && !wr_hit) begin
      valid_q[wr_idx][vic_way] <= 1'b1;
      if (vic_adv) ptr_q[wr_idx] <= ptr_q[wr_idx] + PTR_W'(1);
    end
  end

  // Entry payload storage, guarded only by the valid bits
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx][wr_sel]  <= wr_entry;
      type_q[wr_idx][wr_sel] <= btb_commit_br_type;
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_btb_assoc.sv
// tb/tb_ysyx_24100029_btb_assoc.sv - self-checking bench for the associative BTB
module tb_ysyx_24100029_btb_assoc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] btb_pc = '0;
  logic        btb_is_hit;
  logic [31:0] btb_npc;
  logic [1:0]  btb_br_type;
  logic        btb_taken;
  logic        btb_commit = 1'b0;
  logic [31:0] btb_commit_pc = '0;
  logic [31:0] btb_commit_npc = '0;
  logic        btb_commit_taken = 1'b0;
  logic [1:0]  btb_commit_br_type = '0;
  logic        btb_flush = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [35:0] obs;
  assign obs = {btb_is_hit, btb_npc, btb_br_type, btb_taken};

  always #5 clock = ~clock;

  ysyx_24100029_btb_assoc #(
    .WAYS(4), .INDEX_WIDTH(3), .OFFSET_WIDTH(2), .BRT_WIDTH(2)
  ) dut (
    .clock(clock), .reset(reset), .btb_pc(btb_pc),
    .btb_is_hit(btb_is_hit), .btb_npc(btb_npc), .btb_br_type(btb_br_type), .btb_taken(btb_taken),
    .btb_commit(btb_commit), .btb_commit_pc(btb_commit_pc), .btb_commit_npc(btb_commit_npc),
    .btb_commit_taken(btb_commit_taken), .btb_commit_br_type(btb_commit_br_type),
    .btb_flush(btb_flush)
  );

  // Reference model: 8 sets x 4 ways, entries keyed by full PC
  bit          m_valid [8][4];
  logic [31:0] m_pc    [8][4];
  logic [31:0] m_tgt   [8][4];
  logic [1:0]  m_typ   [8][4];
  int          m_ctr   [8][4];
  int          m_ptr   [8];

  function automatic int m_set(input logic [31:0] pc);
    return int'(pc[4:2]);
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s = m_set(pc);
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_pc[s][w][31:5] == pc[31:5]) return w;
    return -1;
  endfunction

  function automatic logic [35:0] m_expect(input logic [31:0] pc);
    int s = m_set(pc);
    int w = m_find(pc);
    logic tk;
    if (w < 0) return 36'd0;
    tk = (m_ctr[s][w] >= 2) || (m_typ[s][w] != 2'd0);
    return {1'b1, m_tgt[s][w], m_typ[s][w], tk};
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 8; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
    end
  endtask

  task automatic m_commit(input logic [31:0] pc, input logic [31:0] npc, input logic taken,
                          input logic [1:0] typ);
    int s = m_set(pc);
    int w = m_find(pc);
    if (w >= 0) begin
      m_tgt[s][w] = npc;
      m_typ[s][w] = typ;
      m_ctr[s][w] = taken ? ((m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3)
                          : ((m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0);
    end else if (taken) begin
      for (int k = 3; k >= 0; k--) if (!m_valid[s][k]) w = k;
      if (w < 0) begin
        w = m_ptr[s];
        m_ptr[s] = (m_ptr[s] + 1) % 4;
      end
      m_valid[s][w] = 1;
      m_pc[s][w]    = pc;
      m_tgt[s][w]   = npc;
      m_typ[s][w]   = typ;
      m_ctr[s][w]   = 2;
    end
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic [31:0] npc, input logic taken,
                           input logic [1:0] typ);
    btb_commit = 1'b1;
    btb_commit_pc = pc;
    btb_commit_npc = npc;
    btb_commit_taken = taken;
    btb_commit_br_type = typ;
    @(posedge clock);
    m_commit(pc, npc, taken, typ);
    #1;
    btb_commit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btb_commit = 1'b1;
    btb_commit_pc = 32'h8000_0010;
    btb_commit_npc = 32'h8000_0100;
    btb_commit_taken = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    btb_commit = 1'b0;
    m_clear();
    btb_pc = 32'h8000_0010;
    #1;
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL reset_lookup got=%h exp=%h", obs, 36'd0);
    end
  endtask

  task automatic test_alloc();
    btb_pc = 32'h8000_0010;
    btb_commit = 1'b1;
    btb_commit_pc = 32'h8000_0010;
    btb_commit_npc = 32'h8000_0100;
    btb_commit_taken = 1'b1;
    btb_commit_br_type = 2'd0;
    #1;
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL alloc_same_cycle got=%h exp=%h", obs, 36'd0);
    end
    @(posedge clock);
    m_commit(32'h8000_0010, 32'h8000_0100, 1'b1, 2'd0);
    #1;
    btb_commit = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_0100, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL alloc_next_cycle got=%h exp=%h", obs, {1'b1, 32'h8000_0100, 2'd0, 1'b1});
    end
  endtask

  task automatic test_ctr();
    do_commit(32'h8000_0010, 32'h8000_0100, 1'b0, 2'd0);
    btb_pc = 32'h8000_0010;
    #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_0100, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL ctr_dec1 got=%h exp=%h", obs, {1'b1, 32'h8000_0100, 2'd0, 1'b0});
    end
    repeat (2) do_commit(32'h8000_0010, 32'h8000_0100, 1'b0, 2'd0);
    #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_0100, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL ctr_floor got=%h exp=%h", obs, {1'b1, 32'h8000_0100, 2'd0, 1'b0});
    end
    do_commit(32'h8000_0010, 32'h8000_0200, 1'b1, 2'd0);
    #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_0200, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL ctr_inc_from_0 got=%h exp=%h", obs, {1'b1, 32'h8000_0200, 2'd0, 1'b0});
    end
    do_commit(32'h8000_0010, 32'h8000_0200, 1'b1, 2'd0);
    #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_0200, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL ctr_inc_to_2 got=%h exp=%h", obs, {1'b1, 32'h8000_0200, 2'd0, 1'b1});
    end
  endtask

  task automatic test_replace();
    for (int k = 1; k < 4; k++)
      do_commit(32'h8000_0010 + 32'(k) * 32'h20, 32'h8000_1010 + 32'(k) * 32'h20, 1'b1, 2'd0);
    for (int k = 0; k < 4; k++) begin
      btb_pc = 32'h8000_0010 + 32'(k) * 32'h20;
      #1;
      checks++;
      if (obs !== m_expect(btb_pc) || !btb_is_hit) begin
        failures++;
        $display("FAIL fill_way%0d got=%h exp=%h", k, obs, m_expect(btb_pc));
      end
    end
    do_commit(32'h8000_00B0, 32'h8000_10B0, 1'b1, 2'd0);
    btb_pc = 32'h8000_0010;
    #1;
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL evict_way0 got=%h exp=%h", obs, 36'd0);
    end
    btb_pc = 32'h8000_00B0;
    #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_10B0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL fifth_hit got=%h exp=%h", obs, {1'b1, 32'h8000_10B0, 2'd0, 1'b1});
    end
    do_commit(32'h8000_00D0, 32'h8000_10D0, 1'b1, 2'd0);
    btb_pc = 32'h8000_0030;
    #1;
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL evict_way1 got=%h exp=%h", obs, 36'd0);
    end
    btb_pc = 32'h8000_0050;
    #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_1050, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL way2_kept got=%h exp=%h", obs, {1'b1, 32'h8000_1050, 2'd0, 1'b1});
    end
  endtask

  task automatic test_miss_not_taken();
    do_commit(32'h8000_0014, 32'h8000_0400, 1'b0, 2'd0);
    btb_pc = 32'h8000_0014;
    #1;
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL miss_not_taken got=%h exp=%h", obs, 36'd0);
    end
    btb_pc = 32'h8000_00D0;
    #1;
    checks++;
    if (obs !== m_expect(btb_pc)) begin
      failures++;
      $display("FAIL miss_not_taken_other got=%h exp=%h", obs, m_expect(btb_pc));
    end
  endtask

  task automatic test_flush();
    btb_flush = 1'b1;
    btb_commit = 1'b1;
    btb_commit_pc = 32'h8000_0034;
    btb_commit_npc = 32'h8000_0900;
    btb_commit_taken = 1'b1;
    btb_commit_br_type = 2'd1;
    @(posedge clock);
    m_clear();
    #1;
    btb_flush = 1'b0;
    btb_commit = 1'b0;
    foreach (m_ptr[i]) begin end
    for (int k = 0; k < 3; k++) begin
      btb_pc = (k == 0) ? 32'h8000_0034 : (k == 1) ? 32'h8000_0050 : 32'h8000_00D0;
      #1;
      checks++;
      if (obs !== 36'd0) begin
        failures++;
        $display("FAIL flush_miss%0d got=%h exp=%h", k, obs, 36'd0);
      end
    end
    for (int k = 0; k < 5; k++)
      do_commit(32'h8000_0010 + 32'(k) * 32'h20, 32'h8000_1010 + 32'(k) * 32'h20, 1'b1, 2'd0);
    btb_pc = 32'h8000_0010;
    #1;
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL flush_ptr_evict got=%h exp=%h", obs, 36'd0);
    end
    btb_pc = 32'h8000_0050;
    #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_1050, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL flush_ptr_keep got=%h exp=%h", obs, {1'b1, 32'h8000_1050, 2'd0, 1'b1});
    end
    do_commit(32'h8000_0040, 32'h8000_0800, 1'b1, 2'd1);
    do_commit(32'h8000_0040, 32'h8000_0800, 1'b0, 2'd1);
    btb_pc = 32'h8000_0040;
    #1;
    checks++;
    if (obs !== {1'b1, 32'h8000_0800, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL jal_taken got=%h exp=%h", obs, {1'b1, 32'h8000_0800, 2'd1, 1'b1});
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, cpc, cnpc;
    logic        cmt, ctk, fl, rs;
    logic [1:0]  ctyp;
    for (int i = 0; i < 600; i++) begin
      pc   = 32'h8000_0000 + (32'($urandom_range(0, 47)) << 2);
      cpc  = 32'h8000_0000 + (32'($urandom_range(0, 47)) << 2);
      cnpc = $urandom & 32'hFFFF_FFFC;
      cmt  = ($urandom_range(0, 3) != 0);
      ctk  = ($urandom_range(0, 2) != 0);
      ctyp = 2'($urandom_range(0, 3));
      fl   = ($urandom_range(0, 49) == 0);
      rs   = ($urandom_range(0, 79) == 0);
      btb_pc = pc;
      btb_commit = cmt;
      btb_commit_pc = cpc;
      btb_commit_npc = cnpc;
      btb_commit_taken = ctk;
      btb_commit_br_type = ctyp;
      btb_flush = fl;
      reset = rs;
      #1;
      checks++;
      if (obs !== m_expect(pc)) begin
        failures++;
        $display("FAIL random_lookup i=%0d pc=%h got=%h exp=%h", i, pc, obs, m_expect(pc));
      end
      @(posedge clock);
      if (rs || fl) m_clear();
      else if (cmt) m_commit(cpc, cnpc, ctk, ctyp);
      #1;
    end
    btb_commit = 1'b0;
    btb_flush = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_ctr();
    test_replace();
    test_miss_not_taken();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
